// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encodings,
// opcode/funct constants, aluop codes and the ALU operation codes.
package mips_ctrl_pkg;

    localparam int unsigned ALUCTRL_W = 3;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALUOP_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

    // Datapath controls decoded from the current state, before reset masking.
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps (aluop, funct) to the ALU operation, flagging unknown funct.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [ALUOP_W-1:0]   aluop,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALUCTRL_W-1:0] alucontrol_c,
    output logic                 funct_illegal_c
);

    always_comb begin
        alucontrol_c    = ALU_ADD;
        funct_illegal_c = 1'b0;
        case (aluop)
            ALUOP_SUB: alucontrol_c = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol_c = ALU_ADD;
                    F_SUB:   alucontrol_c = ALU_SUB;
                    F_AND:   alucontrol_c = ALU_AND;
                    F_OR:    alucontrol_c = ALU_OR;
                    F_SLT:   alucontrol_c = ALU_SLT;
                    default: funct_illegal_c = 1'b1;
                endcase
            end
            default: alucontrol_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: Moore-decoded datapath selects and enables,
// with pcen the only output that also depends on the ALU zero flag.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic [1:0]           pcsrc,
    output logic                 pcen,
    output logic                 illegal
);

    state_t               state;
    state_t               state_next;
    state_t               dec_state;
    ctrl_t                ctrl;
    logic [ALUOP_W-1:0]   aluop;
    logic                 op_illegal;
    logic [ALUCTRL_W-1:0] alu_dec;
    logic                 funct_illegal;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = funct_illegal ? S_FETCH : S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // During reset the outputs show FETCH selects; enables are masked below.
    assign dec_state = reset ? S_FETCH : state;

    always_comb begin
        ctrl       = '0;
        aluop      = ALUOP_ADD;
        op_illegal = 1'b0;
        case (dec_state)
            S_FETCH: begin
                ctrl.alusrcb = 2'b01;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_illegal = 1'b0;
                    default: op_illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                aluop        = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.pcsrc   = 2'b01;
                ctrl.branch  = 1'b1;
                aluop        = ALUOP_SUB;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_JEX: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop           (aluop),
        .funct           (funct),
        .alucontrol_c    (alu_dec),
        .funct_illegal_c (funct_illegal)
    );

    assign iord       = ctrl.iord;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign pcsrc      = ctrl.pcsrc;
    assign alucontrol = alu_dec;
    assign memwrite   = ctrl.memwrite & ~reset;
    assign irwrite    = ctrl.irwrite  & ~reset;
    assign regwrite   = ctrl.regwrite & ~reset;
    assign pcen       = (ctrl.pcwrite | (ctrl.branch & zero)) & ~reset;
    assign illegal    = (op_illegal | funct_illegal) & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction table,
// reset corner cases, and random instruction streams against a cycle model.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen, illegal;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         lat;
        int         wb;
        logic [2:0] alu2;
        logic       pcen2;
        logic       ill;
    } vec_t;

    outs_t act;
    vec_t  vecs[13];
    int    nvec = 0;
    int    nmis = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .pcen(pcen), .illegal(illegal)
    );

    assign act = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, alucontrol, pcsrc, pcen, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, a, e);
        end
    endtask

    // {legal, alucontrol} for an R-type funct field.
    function automatic logic [3:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return {1'b1, 3'b010};
            6'b100010: return {1'b1, 3'b110};
            6'b100100: return {1'b1, 3'b000};
            6'b100101: return {1'b1, 3'b001};
            6'b101010: return {1'b1, 3'b111};
            default:   return {1'b0, 3'b010};
        endcase
    endfunction

    function automatic int instr_lat(input logic [5:0] o, input logic [5:0] f);
        logic [3:0] r;
        r = rtype_alu(f);
        case (o)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return r[3] ? 4 : 3;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    function automatic outs_t reset_outs();
        outs_t e;
        e = '0;
        e.alusrcb    = 2'b01;
        e.alucontrol = 3'b010;
        return e;
    endfunction

    // Expected outputs in cycle k of an instruction (k=0 is its fetch cycle).
    function automatic outs_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int k);
        outs_t      e;
        logic [3:0] r;
        e = '0;
        e.alucontrol = 3'b010;
        r = rtype_alu(f);
        if (k == 0) begin
            e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1;
        end else if (k == 1) begin
            e.alusrcb = 2'b11;
            e.illegal = !(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
        end else begin
            case (o)
                6'b100011, 6'b101011: begin
                    if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                    else if (k == 3) begin
                        e.iord = 1'b1; e.memwrite = (o == 6'b101011);
                    end else begin
                        e.memtoreg = 1'b1; e.regwrite = 1'b1;
                    end
                end
                6'b000000: begin
                    if (k == 2) begin
                        e.alusrca = 1'b1; e.alucontrol = r[2:0]; e.illegal = !r[3];
                    end else begin
                        e.regdst = 1'b1; e.regwrite = 1'b1;
                    end
                end
                6'b000100: begin
                    e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
                end
                6'b001000: begin
                    if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                    else e.regwrite = 1'b1;
                end
                default: begin
                    e.pcsrc = 2'b10; e.pcen = 1'b1;
                end
            endcase
        end
        return e;
    endfunction

    // Runs one table row, measuring latency and key events directly on the DUT.
    task automatic run_dir(input int idx);
        vec_t       v;
        int         measured;
        int         wb;
        logic [2:0] alu;
        logic       pc;
        logic       ill;
        v = vecs[idx];
        measured = 0; wb = -1; alu = 3'b000; pc = 1'b0; ill = 1'b0;
        for (int k = 0; k < 10; k++) begin
            op    = (k == 0) ? 6'($urandom) : v.op;
            funct = (k == 0) ? 6'($urandom) : v.funct;
            zero  = (k == 2) ? v.zero : 1'($urandom);
            #1;
            if (k > 0 && irwrite) begin
                measured = k;
                break;
            end
            if (memwrite || regwrite) wb = k;
            if (k == 2) begin alu = alucontrol; pc = pcen; end
            if (illegal) ill = 1'b1;
            @(posedge clk); #1;
        end
        check("latency", idx, measured, v.lat);
        check("wb_cycle", idx, wb, v.wb);
        check("illegal", idx, 32'(ill), 32'(v.ill));
        if (v.lat > 2) begin
            check("alu_exec", idx, 32'(alu), 32'(v.alu2));
            check("pcen_exec", idx, 32'(pc), 32'(v.pcen2));
        end
    endtask

    // Runs one instruction comparing every cycle to the model.
    task automatic run_rand(input int idx, input logic [5:0] o, input logic [5:0] f);
        int lat;
        lat = instr_lat(o, f);
        for (int k = 0; k < lat; k++) begin
            op    = (k == 0) ? 6'($urandom) : o;
            funct = (k == 0) ? 6'($urandom) : f;
            zero  = 1'($urandom);
            #1;
            check("rand_cycle", idx * 8 + k, 32'(act), 32'(model(o, f, zero, k)));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [5:0] ro, rf;
        int         pick;
        logic [5:0] functs[5];
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5,  4, 3'b010, 1'b0, 1'b0}; // lw
        vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 4,  3, 3'b010, 1'b0, 1'b0}; // sw
        vecs[2]  = '{6'b000000, 6'b100000, 1'b0, 4,  3, 3'b010, 1'b0, 1'b0}; // add
        vecs[3]  = '{6'b000000, 6'b100010, 1'b0, 4,  3, 3'b110, 1'b0, 1'b0}; // sub
        vecs[4]  = '{6'b000000, 6'b100100, 1'b0, 4,  3, 3'b000, 1'b0, 1'b0}; // and
        vecs[5]  = '{6'b000000, 6'b100101, 1'b0, 4,  3, 3'b001, 1'b0, 1'b0}; // or
        vecs[6]  = '{6'b000000, 6'b101010, 1'b1, 4,  3, 3'b111, 1'b0, 1'b0}; // slt
        vecs[7]  = '{6'b000100, 6'b000000, 1'b1, 3, -1, 3'b110, 1'b1, 1'b0}; // beq taken
        vecs[8]  = '{6'b000100, 6'b000000, 1'b0, 3, -1, 3'b110, 1'b0, 1'b0}; // beq not taken
        vecs[9]  = '{6'b001000, 6'b000000, 1'b0, 4,  3, 3'b010, 1'b0, 1'b0}; // addi
        vecs[10] = '{6'b000010, 6'b000000, 1'b0, 3, -1, 3'b010, 1'b1, 1'b0}; // j
        vecs[11] = '{6'b111111, 6'b000000, 1'b0, 2, -1, 3'b010, 1'b0, 1'b1}; // illegal op
        vecs[12] = '{6'b000000, 6'b000000, 1'b0, 3, -1, 3'b010, 1'b0, 1'b1}; // illegal funct

        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b1;
        #1;
        check("reset_c1", 0, 32'(act), 32'(reset_outs()));
        @(posedge clk); #1;
        check("reset_c2", 0, 32'(act), 32'(reset_outs()));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("first_fetch", 0, 32'(act), 32'(model(6'b0, 6'b0, zero, 0)));

        for (int i = 0; i < 13; i++) run_dir(i);

        // sw aborted by reset in MEMADR, then addi runs normally.
        op = 6'b101011; funct = 6'($urandom); zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sw_memadr_alusrcb", 0, 32'(alusrcb), 32'(2'b10));
        reset = 1'b1;
        #1;
        check("reset_mid", 0, 32'(act), 32'(reset_outs()));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("after_reset_fetch", 0, 32'(act), 32'(model(6'b0, 6'b0, zero, 0)));
        run_dir(9);

        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            rf = 6'($urandom);
            case (pick)
                0:       ro = 6'b100011;
                1:       ro = 6'b101011;
                2, 3:    begin ro = 6'b000000; rf = functs[$urandom_range(0, 4)]; end
                4:       ro = 6'b000000;
                5:       ro = 6'b000100;
                6:       ro = 6'b001000;
                7:       ro = 6'b000010;
                default: ro = 6'($urandom);
            endcase
            run_rand(n, ro, rf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
